defunnel_ctrl_5_1: RTL and testbench

DEFUNNEL_CTRL_5_1 -- requirements
Module: defunnel_ctrl_5_1

---
 rtl/defunnel_ctrl_5_1.sv | 117 +++++++++++
 tb/tb_defunnel_ctrl_5_1.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/defunnel_ctrl_5_1.sv
// defunnel_ctrl_5_1 : control path for a beat-to-word defunnel.
// Collects beats of R lanes (R = 1, 2 or 4) into an 8-slot word and
// presents the assembled word downstream with a valid/ready handshake.
// Optional feature macro: DEFUNNEL_CTRL_FLUSH_EN adds port t_last, which
// terminates a word early on any beat.
module defunnel_ctrl_5_1 (
    input  logic       clk,
    input  logic       reset_n,     // active-high synchronous reset
    input  logic       t_valid,
    output logic       t_ready,
    input  logic [7:0] t_cfg_dat,
    output logic [7:0] mode,
    output logic [7:0] enable,
    output logic       i_0_valid,
    input  logic       i_0_ready,
`ifdef DEFUNNEL_CTRL_FLUSH_EN
    input  logic       t_last,
`endif
    output logic       err_mode
);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q;
    logic [2:0] k_q;
    logic [7:0] mode_q;
    logic       err_q;

    logic       accept;
    logic       word_start;
    logic       cfg_legal;
    logic [7:0] cfg_san;
    logic [2:0] r_eff;
    logic [2:0] last_k;
    logic [7:0] lane_mask;
    logic [3:0] shamt;
    logic       last_beat;
    logic       flush;

`ifdef DEFUNNEL_CTRL_FLUSH_EN
    assign flush = t_last;
`else
    assign flush = 1'b0;
`endif

    // A held word is never overwritten; reset forces the upstream side open.
    assign i_0_valid  = (state_q == HOLD);
    assign t_ready    = reset_n || !i_0_valid || i_0_ready;
    assign accept     = t_valid && t_ready && !reset_n;
    assign word_start = (k_q == 3'd0);

    // Illegal lane counts fall back to one lane per beat.
    assign cfg_legal = (t_cfg_dat[2:0] == 3'd1) || (t_cfg_dat[2:0] == 3'd2) ||
                       (t_cfg_dat[2:0] == 3'd4);
    assign cfg_san   = cfg_legal ? t_cfg_dat : {t_cfg_dat[7:3], 3'd1};

    // The config is only looked at on the first beat of a word.
    assign r_eff = word_start ? cfg_san[2:0] : mode_q[2:0];
    assign mode  = (accept && word_start) ? cfg_san : mode_q;

    // Per-R lane mask, slot offset k*R and final beat index B-1.
    always_comb begin
        lane_mask = 8'h01;
        shamt     = {1'b0, k_q};
        last_k    = 3'd7;
        case (r_eff)
            3'd2: begin
                lane_mask = 8'h03;
                shamt     = {k_q, 1'b0};
                last_k    = 3'd3;
            end
            3'd4: begin
                lane_mask = 8'h0F;
                shamt     = {k_q[1:0], 2'b00};
                last_k    = 3'd1;
            end
            default: begin
                lane_mask = 8'h01;
                shamt     = {1'b0, k_q};
                last_k    = 3'd7;
            end
        endcase
    end

    assign enable    = accept ? (lane_mask << shamt) : 8'h00;
    assign last_beat = accept && ((k_q == last_k) || flush);

    // FILL/HOLD sequencing, beat counter, mode latch and sticky error.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= FILL;
            k_q     <= 3'd0;
            mode_q  <= 8'h01;
            err_q   <= 1'b0;
        end else begin
            if (accept && word_start) begin
                mode_q <= cfg_san;
                if (!cfg_legal) err_q <= 1'b1;
            end
            if (accept) begin
                // An accepted beat in HOLD implies the old word left this edge.
                if (last_beat) begin
                    state_q <= HOLD;
                    k_q     <= 3'd0;
                end else begin
                    state_q <= FILL;
                    k_q     <= k_q + 3'd1;
                end
            end else if (state_q == HOLD && i_0_ready) begin
                state_q <= FILL;
            end
        end
    end

    assign err_mode = err_q;

endmodule

// File: tb/tb_defunnel_ctrl_5_1.sv
// Directed table-driven bench for defunnel_ctrl_5_1.
module tb_defunnel_ctrl_5_1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] t_cfg_dat;
    logic [7:0] mode;
    logic [7:0] enable;
    logic       i_0_valid;
    logic       i_0_ready;
    logic       err_mode;
    logic       t_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    defunnel_ctrl_5_1 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t_valid   (t_valid),
        .t_ready   (t_ready),
        .t_cfg_dat (t_cfg_dat),
        .mode      (mode),
        .enable    (enable),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
`ifdef DEFUNNEL_CTRL_FLUSH_EN
        .t_last    (t_last),
`endif
        .err_mode  (err_mode)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] cfg;
        logic       rdy;
        logic       e_tr;
        logic [7:0] e_en;
        logic       e_val;
        logic [7:0] e_mode;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic v, logic [7:0] cfg, logic rdy,
                                logic e_tr, logic [7:0] e_en, logic e_val,
                                logic [7:0] e_mode, logic e_err);
        vec_t x;
        x.rst = rst; x.v = v; x.cfg = cfg; x.rdy = rdy;
        x.e_tr = e_tr; x.e_en = e_en; x.e_val = e_val;
        x.e_mode = e_mode; x.e_err = e_err;
        return x;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check outputs, then
    // let the rising edge take them.
    task automatic apply(int idx, vec_t x, logic last);
        @(negedge clk);
        reset_n   = x.rst;
        t_valid   = x.v;
        t_cfg_dat = x.cfg;
        i_0_ready = x.rdy;
        t_last    = last;
        #1;
        chk($sformatf("v%0d t_ready", idx),   {7'd0, t_ready},   {7'd0, x.e_tr});
        chk($sformatf("v%0d enable", idx),    enable,            x.e_en);
        chk($sformatf("v%0d i_0_valid", idx), {7'd0, i_0_valid}, {7'd0, x.e_val});
        chk($sformatf("v%0d mode", idx),      mode,              x.e_mode);
        chk($sformatf("v%0d err_mode", idx),  {7'd0, err_mode},  {7'd0, x.e_err});
    endtask

    initial begin
        reset_n = 1'b1; t_valid = 1'b0; t_cfg_dat = 8'h00; i_0_ready = 1'b0; t_last = 1'b0;

        //               rst v  cfg    rdy  tr en     val mode   err
        // reset and idle
        vecs.push_back(mk(1, 0, 8'h00, 0,   1, 8'h00, 0, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0,   1, 8'h00, 0, 8'h01, 0));
        // R=4 back-to-back, downstream ready
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h0F, 0, 8'h04, 0));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'hF0, 0, 8'h04, 0));
        vecs.push_back(mk(0, 0, 8'h04, 1,   1, 8'h00, 1, 8'h04, 0));
        vecs.push_back(mk(0, 0, 8'h04, 1,   1, 8'h00, 0, 8'h04, 0));
        // R=1 with gaps
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h01, 0, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h01, 1,   1, 8'h00, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h02, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h04, 0, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h01, 1,   1, 8'h00, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h08, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h10, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h20, 0, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h01, 1,   1, 8'h00, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h40, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h01, 1,   1, 8'h80, 0, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h01, 1,   1, 8'h00, 1, 8'h01, 0));
        vecs.push_back(mk(0, 0, 8'h01, 1,   1, 8'h00, 0, 8'h01, 0));
        // R=2 (upper mode bits carried), downstream stalls 5 cycles
        vecs.push_back(mk(0, 1, 8'h52, 0,   1, 8'h03, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 0,   1, 8'h0C, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 0,   1, 8'h30, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 0,   1, 8'hC0, 0, 8'h52, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 8'h52, 0, 0, 8'h00, 1, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 1,   1, 8'h03, 1, 8'h52, 0));
        vecs.push_back(mk(0, 0, 8'h52, 1,   1, 8'h00, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 1,   1, 8'h0C, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 1,   1, 8'h30, 0, 8'h52, 0));
        vecs.push_back(mk(0, 1, 8'h52, 1,   1, 8'hC0, 0, 8'h52, 0));
        vecs.push_back(mk(0, 0, 8'h52, 1,   1, 8'h00, 1, 8'h52, 0));
        // illegal R=3 -> R=1, sticky error, mid-word cfg change ignored
        vecs.push_back(mk(0, 1, 8'h03, 1,   1, 8'h01, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h03, 1,   1, 8'h02, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h03, 1,   1, 8'h04, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h08, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h10, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h20, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h40, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h80, 0, 8'h01, 1));
        vecs.push_back(mk(0, 0, 8'h04, 1,   1, 8'h00, 1, 8'h01, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'h0F, 0, 8'h04, 1));
        vecs.push_back(mk(0, 1, 8'h04, 1,   1, 8'hF0, 0, 8'h04, 1));
        vecs.push_back(mk(0, 0, 8'h04, 1,   1, 8'h00, 1, 8'h04, 1));
        // reset at k=2 of an R=2 word wins over a concurrent beat
        vecs.push_back(mk(0, 1, 8'h02, 1,   1, 8'h03, 0, 8'h02, 1));
        vecs.push_back(mk(0, 1, 8'h02, 1,   1, 8'h0C, 0, 8'h02, 1));
        vecs.push_back(mk(1, 1, 8'h02, 1,   1, 8'h00, 0, 8'h02, 1));
        vecs.push_back(mk(0, 0, 8'h02, 1,   1, 8'h00, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0,   1, 8'h0F, 0, 8'h04, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0,   1, 8'hF0, 0, 8'h04, 0));
        // reset while holding a word drops it
        vecs.push_back(mk(0, 1, 8'h04, 0,   0, 8'h00, 1, 8'h04, 0));
        vecs.push_back(mk(1, 1, 8'h04, 0,   1, 8'h00, 1, 8'h04, 0));
        vecs.push_back(mk(0, 0, 8'h04, 0,   1, 8'h00, 0, 8'h01, 0));

        foreach (vecs[i]) apply(i, vecs[i], 1'b0);

`ifdef DEFUNNEL_CTRL_FLUSH_EN
        // R=1 word cut short by t_last on its third beat
        apply(100, mk(0, 1, 8'h01, 1, 1, 8'h01, 0, 8'h01, 0), 1'b0);
        apply(101, mk(0, 1, 8'h01, 1, 1, 8'h02, 0, 8'h01, 0), 1'b0);
        apply(102, mk(0, 1, 8'h01, 1, 1, 8'h04, 0, 8'h01, 0), 1'b1);
        apply(103, mk(0, 0, 8'h01, 0, 0, 8'h00, 1, 8'h01, 0), 1'b0);
        apply(104, mk(0, 1, 8'h01, 1, 1, 8'h01, 1, 8'h01, 0), 1'b0);
        apply(105, mk(0, 1, 8'h01, 1, 1, 8'h02, 0, 8'h01, 0), 1'b0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
